spring_particle_n: RTL and testbench

- Parametrised successor to the single-node spring particle.
- Integrates one mass node against N_NBR spring-coupled neighbours with Verlet integration, driven by a start/done handshake instead of a free-running phase counter.
- Spring acceleration is accumulated and applied in the same step.
- One shared multiplier, a saturating datapath, L1 spring length, and per-neighbour enable.
- Sits in the mesh array; the mesh controller pulses step once per frame.

---
 rtl/particle_pkg.sv | 48 ++++
 rtl/spring_particle_n_if.sv | 20 ++
 rtl/spring_mac.sv | 22 ++
 rtl/spring_particle_n.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_spring_particle_n.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/particle_pkg.sv
// Shared types for the spring mesh node: word type, FSM states,
// saturation helper and button force directions.
package particle_pkg;

  localparam int WORD_W = 16;

  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FORCE,
    S_DIFF,
    S_DAMP_X,
    S_DAMP_Y,
    S_APPLY_X,
    S_APPLY_Y,
    S_INTEG,
    S_VEL,
    S_BOUND,
    S_DONE
  } state_e;

  typedef struct packed {
    logic signed [1:0] sx;
    logic signed [1:0] sy;
  } dir_t;

  // Screen coordinates: up is toward smaller y.
  localparam dir_t DIR_NONE  = '{sx: 2'sd0,  sy: 2'sd0};
  localparam dir_t DIR_LEFT  = '{sx: -2'sd1, sy: 2'sd0};
  localparam dir_t DIR_RIGHT = '{sx: 2'sd1,  sy: 2'sd0};
  localparam dir_t DIR_UP    = '{sx: 2'sd0,  sy: -2'sd1};
  localparam dir_t DIR_DOWN  = '{sx: 2'sd0,  sy: 2'sd1};

  function automatic logic signed [63:0] sat_w(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/spring_particle_n_if.sv
// Step/busy/done handshake between the mesh controller and a node.
interface spring_particle_n_if;

  logic step;
  logic busy;
  logic done;

  modport master (
    output step,
    input  busy,
    input  done
  );

  modport slave (
    input  step,
    output busy,
    output done
  );

endinterface

// File: rtl/spring_mac.sv
// Shared signed multiplier: (add + a*b) >>> sh, saturated to W bits.
module spring_mac #(
  parameter int W = 16
) (
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  input  logic signed [2*W-1:0] add_i,
  input  logic [4:0]            sh_i,
  output logic signed [2*W:0]   sum_o,
  output logic signed [W-1:0]   res_o
);
  import particle_pkg::*;

  logic signed [2*W-1:0] prod;

  always_comb begin
    prod  = (2*W)'(a_i) * (2*W)'(b_i);
    sum_o = (2*W+1)'(prod) + (2*W+1)'(add_i);
    res_o = W'(sat_w(64'(sum_o >>> sh_i), W));
  end

endmodule

// File: rtl/spring_particle_n.sv
// Verlet mass node coupled to N_NBR spring neighbours, one step per start.
// Define SPRING_DAMPING_EN to add the relative-velocity damping term.
module spring_particle_n #(
  parameter int W            = 16,
  parameter int N_NBR        = 3,
  parameter int INIT_X       = 128,
  parameter int INIT_Y       = 128,
  parameter int REST         = 64,
  parameter int MASS_SHIFT   = 4,
  parameter int SPRING_SHIFT = 3,
  parameter int DAMP_SHIFT   = 2,
  parameter int NORM_SHIFT   = 6,
  parameter int FORCE_MAG    = 4,
  parameter int BOUND        = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  spring_particle_n_if.slave     ctl,
  input  logic [N_NBR*W-1:0]     nbr_x,
  input  logic [N_NBR*W-1:0]     nbr_y,
  input  logic [N_NBR*W-1:0]     nbr_vx,
  input  logic [N_NBR*W-1:0]     nbr_vy,
  input  logic [N_NBR-1:0]       nbr_valid,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_up,
  input  logic                   btn_down,
  output logic signed [W-1:0]    x,
  output logic signed [W-1:0]    y,
  output logic signed [W-1:0]    vel_x,
  output logic signed [W-1:0]    vel_y,
  output logic signed [W-1:0]    m
);
  import particle_pkg::*;

  localparam int IW = (N_NBR > 1) ? $clog2(N_NBR) : 1;
  localparam logic signed [63:0] BND = 64'(BOUND);

  typedef logic signed [W-1:0] sw_t;
  typedef logic signed [63:0]  wide_t;

  function automatic sw_t sw(input wide_t v);
    return sw_t'(sat_w(v, W));
  endfunction

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;

  sw_t x_q, y_q, px_q, py_q;
  sw_t vx_q, vy_q, ax_q, ay_q;
  sw_t dx_q, dy_q, disp_q;

  sw_t   nx, ny, fx, fy;
  sw_t   dx_s, dy_s, disp_s;
  sw_t   term, damp_v;
  sw_t   acc_nx, acc_ny;
  sw_t   xi, yi, vxi, vyi;
  sw_t   xc, yc, vxb, vyb, pxb, pyb;
  wide_t d_w;
  logic  nv, last, clip_x, clip_y;
  dir_t  dir;

  sw_t                   mac_a, mac_b, mac_res;
  logic signed [2*W-1:0] mac_add;
  logic signed [2*W:0]   mac_sum;
  logic [4:0]            mac_sh;

`ifdef SPRING_DAMPING_EN
  logic signed [2*W-1:0] p_q;
  sw_t                   damp_q;
  sw_t                   nvx, nvy, dvx, dvy;

  always_comb begin
    nvx = $signed(nbr_vx[W*int'(idx_q) +: W]);
    nvy = $signed(nbr_vy[W*int'(idx_q) +: W]);
    dvx = sw(wide_t'(vx_q) - wide_t'(nvx));
    dvy = sw(wide_t'(vy_q) - wide_t'(nvy));
  end

  assign damp_v = damp_q;
`else
  logic unused_ok;
  assign unused_ok = ^{nbr_vx, nbr_vy, mac_sum, DAMP_SHIFT[0]};
  assign damp_v    = '0;
`endif

  spring_mac #(.W(W)) u_mac (
    .a_i   (mac_a),
    .b_i   (mac_b),
    .add_i (mac_add),
    .sh_i  (mac_sh),
    .sum_o (mac_sum),
    .res_o (mac_res)
  );

  always_comb begin
    nx   = $signed(nbr_x[W*int'(idx_q) +: W]);
    ny   = $signed(nbr_y[W*int'(idx_q) +: W]);
    nv   = nbr_valid[idx_q];
    last = (idx_q == IW'(N_NBR - 1));

    dx_s   = sw(wide_t'(x_q) - wide_t'(nx));
    dy_s   = sw(wide_t'(y_q) - wide_t'(ny));
    d_w    = (dx_s[W-1] ? -wide_t'(dx_s) : wide_t'(dx_s))
           + (dy_s[W-1] ? -wide_t'(dy_s) : wide_t'(dy_s));
    disp_s = sw(d_w - wide_t'(REST));

    term   = sw((wide_t'(disp_q) <<< SPRING_SHIFT)
           + wide_t'(damp_v));
    acc_nx = sw(wide_t'(ax_q) - wide_t'(mac_res));
    acc_ny = sw(wide_t'(ay_q) - wide_t'(mac_res));

    xi  = sw((wide_t'(x_q) <<< 1) - wide_t'(px_q)
        + ((wide_t'(ax_q) >>> MASS_SHIFT) <<< 2));
    yi  = sw((wide_t'(y_q) <<< 1) - wide_t'(py_q)
        + ((wide_t'(ay_q) >>> MASS_SHIFT) <<< 2));
    vxi = sw((wide_t'(x_q) - wide_t'(px_q)) >>> 1);
    vyi = sw((wide_t'(y_q) - wide_t'(py_q)) >>> 1);

    // A clamped axis bounces back at half speed.
    clip_x = x_q[W-1] || (wide_t'(x_q) >= BND);
    clip_y = y_q[W-1] || (wide_t'(y_q) >= BND);
    xc     = x_q[W-1] ? '0 : sw_t'(BOUND - 1);
    yc     = y_q[W-1] ? '0 : sw_t'(BOUND - 1);
    vxb    = sw(-(wide_t'(vx_q) >>> 1));
    vyb    = sw(-(wide_t'(vy_q) >>> 1));
    pxb    = sw(wide_t'(xc) - (wide_t'(vxb) <<< 1));
    pyb    = sw(wide_t'(yc) - (wide_t'(vyb) <<< 1));

    dir = DIR_NONE;
    if (btn_left)       dir = DIR_LEFT;
    else if (btn_right) dir = DIR_RIGHT;
    else if (btn_up)    dir = DIR_UP;
    else if (btn_down)  dir = DIR_DOWN;
    fx = sw(64'($signed(dir.sx)) * 64'(FORCE_MAG));
    fy = sw(64'($signed(dir.sy)) * 64'(FORCE_MAG));
  end

  always_comb begin
    mac_a   = '0;
    mac_b   = '0;
    mac_add = '0;
    mac_sh  = '0;
    unique case (state_q)
`ifdef SPRING_DAMPING_EN
      S_DAMP_X: begin
        mac_a = dvx;
        mac_b = dx_q;
      end
      S_DAMP_Y: begin
        mac_a   = dvy;
        mac_b   = dy_q;
        mac_add = p_q;
        mac_sh  = 5'(DAMP_SHIFT);
      end
`endif
      S_APPLY_X: begin
        mac_a  = term;
        mac_b  = dx_q;
        mac_sh = 5'(NORM_SHIFT);
      end
      S_APPLY_Y: begin
        mac_a  = term;
        mac_b  = dy_q;
        mac_sh = 5'(NORM_SHIFT);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ctl.busy = (state_q != S_IDLE);
    ctl.done = (state_q == S_DONE);
    unique case (state_q)
      S_IDLE:  if (ctl.step) state_d = S_FORCE;
      S_FORCE: begin
        state_d = S_DIFF;
        idx_d   = '0;
      end
      S_DIFF: begin
        if (!nv || d_w == '0) begin
          if (last) state_d = S_INTEG;
          else      idx_d   = idx_q + IW'(1);
        end else begin
`ifdef SPRING_DAMPING_EN
          state_d = S_DAMP_X;
`else
          state_d = S_APPLY_X;
`endif
        end
      end
`ifdef SPRING_DAMPING_EN
      S_DAMP_X: state_d = S_DAMP_Y;
      S_DAMP_Y: state_d = S_APPLY_X;
`endif
      S_APPLY_X: state_d = S_APPLY_Y;
      S_APPLY_Y: begin
        if (last) begin
          state_d = S_INTEG;
        end else begin
          state_d = S_DIFF;
          idx_d   = idx_q + IW'(1);
        end
      end
      S_INTEG: state_d = S_VEL;
      S_VEL:   state_d = S_BOUND;
      S_BOUND: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      x_q     <= sw_t'(INIT_X);
      y_q     <= sw_t'(INIT_Y);
      px_q    <= sw_t'(INIT_X);
      py_q    <= sw_t'(INIT_Y);
      vx_q    <= '0;
      vy_q    <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      disp_q  <= '0;
`ifdef SPRING_DAMPING_EN
      p_q     <= '0;
      damp_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      unique case (state_q)
        S_FORCE: begin
          ax_q <= fx;
          ay_q <= fy;
        end
        S_DIFF: begin
          dx_q   <= dx_s;
          dy_q   <= dy_s;
          disp_q <= disp_s;
        end
`ifdef SPRING_DAMPING_EN
        S_DAMP_X: p_q    <= (2*W)'(mac_sum);
        S_DAMP_Y: damp_q <= mac_res;
`endif
        S_APPLY_X: ax_q <= acc_nx;
        S_APPLY_Y: ay_q <= acc_ny;
        S_INTEG: begin
          x_q  <= xi;
          y_q  <= yi;
          px_q <= x_q;
          py_q <= y_q;
        end
        S_VEL: begin
          vx_q <= vxi;
          vy_q <= vyi;
        end
        S_BOUND: begin
          if (clip_x) begin
            x_q  <= xc;
            vx_q <= vxb;
            px_q <= pxb;
          end
          if (clip_y) begin
            y_q  <= yc;
            vy_q <= vyb;
            py_q <= pyb;
          end
        end
        default: ;
      endcase
    end
  end

  assign x     = x_q;
  assign y     = y_q;
  assign vel_x = vx_q;
  assign vel_y = vy_q;
  assign m     = sw_t'(1 << MASS_SHIFT);

endmodule

// File: tb/tb_spring_particle_n.sv
// Randomized bench for spring_particle_n against a per-step arithmetic model.
module tb_spring_particle_n;

  localparam int W    = 16;
  localparam int N    = 3;
  localparam int REST = 64;
  localparam int MS   = 4;
  localparam int SS   = 3;
  localparam int DS   = 2;
  localparam int NS   = 6;
  localparam int FM   = 4;
  localparam int BND  = 256;
`ifdef SPRING_DAMPING_EN
  localparam int K = 5;
`else
  localparam int K = 3;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N*W-1:0] nbr_x, nbr_y, nbr_vx, nbr_vy;
  logic [N-1:0]   nbr_valid;
  logic bl, br, bu, bd;
  logic signed [W-1:0] x, y, vel_x, vel_y, m;

  spring_particle_n_if ctl();

  spring_particle_n dut (
    .clk       (clk),
    .reset     (rst_n),
    .ctl       (ctl),
    .nbr_x     (nbr_x),
    .nbr_y     (nbr_y),
    .nbr_vx    (nbr_vx),
    .nbr_vy    (nbr_vy),
    .nbr_valid (nbr_valid),
    .btn_left  (bl),
    .btn_right (br),
    .btn_up    (bu),
    .btn_down  (bd),
    .x         (x),
    .y         (y),
    .vel_x     (vel_x),
    .vel_y     (vel_y),
    .m         (m)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  longint mx, my, mpx, mpy, mvx, mvy;
  int nbx[N], nby[N], nbvx[N], nbvy[N];
  bit nbv[N];
  bit b[4];

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat(input longint v);
    longint hi;
    hi = (longint'(1) <<< (W - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    mx = 128; my = 128; mpx = 128; mpy = 128;
    mvx = 0; mvy = 0;
  endtask

  task automatic axis(inout longint p, inout longint pp,
                      inout longint v, input longint a);
    longint pn;
    pn = sat(2 * p - pp + ((a >>> MS) * 4));
    pp = p;
    p  = pn;
    v  = sat((p - pp) >>> 1);
    if (p < 0 || p >= BND) begin
      p  = (p < 0) ? 0 : BND - 1;
      v  = sat(-(v >>> 1));
      pp = sat(p - 2 * v);
    end
  endtask

  task automatic model_step(output int lat);
    longint ax, ay, dx, dy, d, disp, damp, term;
    int skip, nv;
    skip = 0; nv = 0; ax = 0; ay = 0;
    if (b[0])      ax = -FM;
    else if (b[1]) ax = FM;
    else if (b[2]) ay = -FM;
    else if (b[3]) ay = FM;
    for (int i = 0; i < N; i++) begin
      dx = sat(mx - nbx[i]);
      dy = sat(my - nby[i]);
      d  = labs(dx) + labs(dy);
      if (!nbv[i] || d == 0) begin
        skip++;
        continue;
      end
      nv++;
      disp = sat(d - REST);
      damp = 0;
`ifdef SPRING_DAMPING_EN
      damp = sat((sat(mvx - nbvx[i]) * dx
                + sat(mvy - nbvy[i]) * dy) >>> DS);
`endif
      term = sat(disp * (1 << SS) + damp);
      ax = sat(ax - sat((term * dx) >>> NS));
      ay = sat(ay - sat((term * dy) >>> NS));
    end
    axis(mx, mpx, mvx, ax);
    axis(my, mpy, mvy, ay);
    lat = 4 + skip + K * nv;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      nbr_x[i*W +: W]  = W'(nbx[i]);
      nbr_y[i*W +: W]  = W'(nby[i]);
      nbr_vx[i*W +: W] = W'(nbvx[i]);
      nbr_vy[i*W +: W] = W'(nbvy[i]);
      nbr_valid[i]     = nbv[i];
    end
    {bl, br, bu, bd} = {b[0], b[1], b[2], b[3]};
  endtask

  task automatic quiet();
    for (int i = 0; i < N; i++) begin
      nbx[i] = 0; nby[i] = 0; nbvx[i] = 0; nbvy[i] = 0;
      nbv[i] = 1'b0;
    end
    for (int j = 0; j < 4; j++) b[j] = 1'b0;
  endtask

  task automatic randomize_in();
    for (int i = 0; i < N; i++) begin
      nbv[i] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        nbx[i] = int'(mx);
        nby[i] = int'(my);
      end else begin
        nbx[i] = int'(mx) + int'($urandom_range(0, 500)) - 250;
        nby[i] = int'(my) + int'($urandom_range(0, 500)) - 250;
      end
      nbvx[i] = int'($urandom_range(0, 80)) - 40;
      nbvy[i] = int'($urandom_range(0, 80)) - 40;
    end
    for (int j = 0; j < 4; j++) b[j] = ($urandom_range(0, 3) == 0);
  endtask

  task automatic run_step(input int exp_lat, input string tag);
    int k;
    bit seen;
    @(negedge clk);
    ctl.step = 1'b1;
    @(negedge clk);
    ctl.step = 1'b0;
    chk({tag, "_busy"}, ctl.busy, 1);
    k = 0;
    seen = 1'b0;
    while (k < 200 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 3) ctl.step = 1'b1;
      if (k == 4) ctl.step = 1'b0;
      if (ctl.done) seen = 1'b1;
    end
    ctl.step = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, k, exp_lat);
    @(negedge clk);
    chk({tag, "_done_once"}, ctl.done, 0);
    chk({tag, "_idle"}, ctl.busy, 0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_x"}, x, mx);
    chk({tag, "_y"}, y, my);
    chk({tag, "_vx"}, vel_x, mvx);
    chk({tag, "_vy"}, vel_y, mvy);
  endtask

  initial begin
    int lat;
    n_chk = 0;
    n_fail = 0;
    ctl.step = 1'b0;
    quiet();
    drive();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset");
    chk("reset_busy", ctl.busy, 0);
    chk("reset_done", ctl.done, 0);
    chk("mass", m, 16);
    rst_n = 1'b1;

    model_step(lat);
    run_step(lat, "no_nbr");
    check_state("no_nbr");
    chk("no_nbr_x_rest", x, 128);

    quiet();
    nbv[0] = 1'b1;
    nbx[0] = 228;
    nby[0] = 128;
    drive();
    model_step(lat);
    run_step(lat, "one_nbr");
    check_state("one_nbr");
    chk("one_nbr_x", x, 240);
    chk("one_nbr_vx", vel_x, 56);

    for (int s = 0; s < 40; s++) begin
      randomize_in();
      drive();
      model_step(lat);
      run_step(lat, $sformatf("rnd%0d", s));
      check_state($sformatf("rnd%0d", s));
    end

    randomize_in();
    for (int i = 0; i < N; i++) nbv[i] = 1'b1;
    drive();
    @(negedge clk);
    ctl.step = 1'b1;
    @(negedge clk);
    ctl.step = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("abort");
    chk("abort_busy", ctl.busy, 0);
    chk("abort_done", ctl.done, 0);
    repeat (2) @(negedge clk);
    chk("abort_hold_done", ctl.done, 0);
    rst_n = 1'b1;

    quiet();
    drive();
    model_step(lat);
    run_step(lat, "post");
    check_state("post");
    chk("post_x_rest", x, 128);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
